// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: merges pipeline writeback with a FIFO of
// long-latency returns, tracks pending destinations, and requests bubbles on starvation.
// Optional writeback trace enabled by defining WB_TRACE_EN.
module regfile_wb_ctrl #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_we,
   input  logic [4:0]  pipe_wr,
   input  logic [31:0] pipe_wd,
   input  logic        lu_valid,
   output logic        lu_ready,
   input  logic [4:0]  lu_wr,
   input  logic [31:0] lu_wd,
   input  logic        issue_valid,
   input  logic [4:0]  issue_wr,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   output logic        rs_busy,
   output logic        rt_busy,
   output logic [31:0] pend,
   output logic        wb_stall,
   output logic        rf_we,
   output logic [4:0]  rf_wr,
   output logic [31:0] rf_wd
);

   localparam int unsigned RW   = 5;
   localparam int unsigned DW   = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CW   = AW + 1;
   localparam int unsigned WW   = $clog2(MAX_WAIT) + 1;

   logic [RW-1:0]   mem_wr [DEPTH];
   logic [DW-1:0]   mem_wd [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_n;
   logic [WW-1:0]   wait_cnt;
   logic [WW-1:0]   wait_n;
   logic            stall_n;
   logic [NREG-1:0] pend_n;

   logic            full;
   logic            empty;
   logic            pipe_act;
   logic            push;
   logic            pop;
   logic            head_act;
   logic [RW-1:0]   head_wr;
   logic [DW-1:0]   head_wd;

   // FIFO status and handshake; reset forces the port quiet immediately
   always_comb begin
      full     = (count == CW'(DEPTH));
      empty    = (count == '0);
      head_wr  = mem_wr[rd_ptr];
      head_wd  = mem_wd[rd_ptr];
      pipe_act = pipe_we && (pipe_wr != '0);
      push     = !rst && lu_valid && !full;
      pop      = !rst && !empty && !pipe_act;
      head_act = pop && (head_wr != '0);
      lu_ready = !rst && !full;
   end

   // Write-port mux: pipeline has priority, otherwise the FIFO head drains
   always_comb begin
      rf_we = !rst && (pipe_act || head_act);
      rf_wr = head_wr;
      rf_wd = head_wd;
      if (pipe_act) begin
         rf_wr = pipe_wr;
         rf_wd = pipe_wd;
      end
   end

   always_comb begin
      rs_busy = pend[rs];
      rt_busy = pend[rt];
   end

   // Next-state for occupancy, scoreboard and starvation tracking
   always_comb begin
      count_n = count;
      unique case ({push, pop})
         2'b10:   count_n = count + CW'(1);
         2'b01:   count_n = count - CW'(1);
         default: count_n = count;
      endcase

      pend_n = pend;
      if (head_act)
         pend_n[head_wr] = 1'b0;
      if (issue_valid && (issue_wr != '0))
         pend_n[issue_wr] = 1'b1;
      pend_n[0] = 1'b0;

      wait_n = wait_cnt;
      if (empty || pop)
         wait_n = '0;
      else if (wait_cnt != WW'(MAX_WAIT - 1))
         wait_n = wait_cnt + WW'(1);

      stall_n = wb_stall;
      if (pop)
         stall_n = 1'b0;
      else if (!empty && (wait_cnt == WW'(MAX_WAIT - 1)))
         stall_n = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         pend     <= '0;
         wait_cnt <= '0;
         wb_stall <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count    <= count_n;
         pend     <= pend_n;
         wait_cnt <= wait_n;
         wb_stall <= stall_n;
      end
   end

   // Payload storage needs no reset; occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         mem_wr[wr_ptr] <= lu_wr;
         mem_wd[wr_ptr] <= lu_wd;
      end
   end

`ifdef WB_TRACE_EN
   localparam int unsigned OW = $clog2(MAX_WAIT + 2);

   logic [OW-1:0] ovf_cnt;

   // Consecutive cycles a return was offered while the FIFO was full
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf_cnt <= '0;
      else if (lu_valid && full) begin
         if (ovf_cnt != OW'(MAX_WAIT + 1))
            ovf_cnt <= ovf_cnt + OW'(1);
      end else
         ovf_cnt <= '0;
   end

   always_ff @(posedge clk) begin
      if (rf_we)
         $display("WB src=%s R[%0d]=%08X", pipe_act ? "P" : "L", rf_wr, rf_wd);
      if (!rst && lu_valid && full && (ovf_cnt == OW'(MAX_WAIT)))
         $display("WB overflow");
   end
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with a return-queue scoreboard and a pend model.
module tb_regfile_wb_ctrl;

   localparam int unsigned DEPTH    = 4;
   localparam int unsigned MAX_WAIT = 8;

   typedef struct packed {
      logic [4:0]  wr;
      logic [31:0] wd;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_wr;
   logic [31:0] pipe_wd;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_wr;
   logic [31:0] lu_wd;
   logic        issue_valid;
   logic [4:0]  issue_wr;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        rs_busy;
   logic        rt_busy;
   logic [31:0] pend;
   logic        wb_stall;
   logic        rf_we;
   logic [4:0]  rf_wr;
   logic [31:0] rf_wd;

   int          checks = 0;
   int          errors = 0;
   ent_t        exp_q[$];
   logic [31:0] m_pend = '0;

   regfile_wb_ctrl #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .pipe_we(pipe_we), .pipe_wr(pipe_wr), .pipe_wd(pipe_wd),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wr(lu_wr), .lu_wd(lu_wd),
      .issue_valid(issue_valid), .issue_wr(issue_wr),
      .rs(rs), .rt(rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
      .pend(pend), .wb_stall(wb_stall),
      .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: compare outputs mid-cycle against the model, then advance the model
   task automatic step();
      logic pact;
      logic do_push;
      ent_t h;
      @(negedge clk);
      pact = pipe_we && (pipe_wr != 5'd0);
      check("lu_ready", {31'd0, lu_ready}, {31'd0, exp_q.size() < DEPTH});
      check("pend", pend, m_pend);
      if (pact) begin
         check("rf_we_pipe", {31'd0, rf_we}, 32'd1);
         check("rf_wr_pipe", {27'd0, rf_wr}, {27'd0, pipe_wr});
         check("rf_wd_pipe", rf_wd, pipe_wd);
      end else if (exp_q.size() > 0) begin
         h = exp_q[0];
         check("rf_we_lu", {31'd0, rf_we}, {31'd0, h.wr != 5'd0});
         if (h.wr != 5'd0) begin
            check("rf_wr_lu", {27'd0, rf_wr}, {27'd0, h.wr});
            check("rf_wd_lu", rf_wd, h.wd);
         end
      end else begin
         check("rf_we_idle", {31'd0, rf_we}, 32'd0);
      end
      do_push = lu_valid && (exp_q.size() < DEPTH);
      if (!pact && exp_q.size() > 0) begin
         h = exp_q.pop_front();
         if (h.wr != 5'd0)
            m_pend[h.wr] = 1'b0;
      end
      if (issue_valid && issue_wr != 5'd0)
         m_pend[issue_wr] = 1'b1;
      if (do_push)
         exp_q.push_back({lu_wr, lu_wd});
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; pipe_we = 1'b0; pipe_wr = '0; pipe_wd = '0;
      lu_valid = 1'b0; lu_wr = '0; lu_wd = '0;
      issue_valid = 1'b0; issue_wr = '0; rs = '0; rt = '0;

      // Reset and idle
      repeat (2) @(posedge clk);
      #1;
      check("rst_lu_ready", {31'd0, lu_ready}, 32'd0);
      check("rst_rf_we", {31'd0, rf_we}, 32'd0);
      check("rst_pend", pend, 32'd0);
      check("rst_stall", {31'd0, wb_stall}, 32'd0);
      rst = 1'b0;
      #1;
      check("idle_lu_ready", {31'd0, lu_ready}, 32'd1);
      step();
      step();
      check("idle_stall", {31'd0, wb_stall}, 32'd0);

      // Issue R5, return DEADBEEF, drain one cycle later
      issue_valid = 1'b1; issue_wr = 5'd5;
      step();
      issue_valid = 1'b0;
      check("pend5_set", {31'd0, pend[5]}, 32'd1);
      lu_valid = 1'b1; lu_wr = 5'd5; lu_wd = 32'hDEAD_BEEF; rs = 5'd5;
      step();
      lu_valid = 1'b0;
      #1;
      check("rs_busy_drain_cycle", {31'd0, rs_busy}, 32'd1);
      step();
      check("pend5_clr", {31'd0, pend[5]}, 32'd0);
      check("rs_busy_after", {31'd0, rs_busy}, 32'd0);

      // Continuous pipeline writes starve four returns until a stall
      pipe_we = 1'b1; pipe_wr = 5'd3; pipe_wd = 32'h11;
      lu_valid = 1'b1; lu_wr = 5'd8; lu_wd = 32'h8888_0008;
      step();
      for (int i = 1; i <= 8; i++) begin
         if (i <= 4) begin
            lu_valid = 1'b1;
            lu_wr    = 5'(8 + i);
            lu_wd    = 32'h8888_0000 + 32'(8 + i);
         end else begin
            lu_valid = 1'b0;
         end
         step();
         check($sformatf("wb_stall_w%0d", i), {31'd0, wb_stall}, {31'd0, i == 8});
      end
      check("full_lu_ready", {31'd0, lu_ready}, 32'd0);
      pipe_we = 1'b0;
      step();
      check("stall_cleared", {31'd0, wb_stall}, 32'd0);
      repeat (3) step();
      check("drained_lu_ready", {31'd0, lu_ready}, 32'd1);

      // Return to R0 is consumed silently; pipe write to R0 lets the FIFO drain
      lu_valid = 1'b1; lu_wr = 5'd0; lu_wd = 32'h1234;
      step();
      lu_valid = 1'b0;
      step();
      pipe_we = 1'b1; pipe_wr = 5'd0; pipe_wd = 32'hFFFF;
      lu_valid = 1'b1; lu_wr = 5'd12; lu_wd = 32'hC0C0;
      step();
      lu_valid = 1'b0;
      step();
      pipe_we = 1'b0;
      step();

      // Same-cycle issue and drain of R7: set wins
      issue_valid = 1'b1; issue_wr = 5'd7;
      lu_valid = 1'b1; lu_wr = 5'd7; lu_wd = 32'h77;
      step();
      lu_valid = 1'b0; rs = 5'd7; rt = 5'd0;
      step();
      issue_valid = 1'b0;
      check("pend7_setwins", {31'd0, pend[7]}, 32'd1);
      check("rs_busy7", {31'd0, rs_busy}, 32'd1);
      check("rt_busy0", {31'd0, rt_busy}, 32'd0);

      // Reset with two buffered returns
      pipe_we = 1'b1; pipe_wr = 5'd3; pipe_wd = 32'h22;
      issue_valid = 1'b1; issue_wr = 5'd9;
      lu_valid = 1'b1; lu_wr = 5'd9; lu_wd = 32'h99;
      step();
      issue_valid = 1'b0; lu_wr = 5'd10; lu_wd = 32'hAA;
      step();
      lu_valid = 1'b0; pipe_we = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_lu_ready", {31'd0, lu_ready}, 32'd0);
      check("midrst_rf_we", {31'd0, rf_we}, 32'd0);
      check("midrst_pend", pend, 32'd0);
      check("midrst_stall", {31'd0, wb_stall}, 32'd0);
      exp_q.delete();
      m_pend = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("postrst_lu_ready", {31'd0, lu_ready}, 32'd1);
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
